// File: rtl/krake_tx_fifo_port_pkg.sv
// Shared definitions for the Krake FIFO-backed UART transmit port.
// Holds the register addresses, the CTRL/STATUS bit positions and the serializer states.
package krake_tx_pkg;

  localparam logic [3:0] TXP_STATUS = 4'h0;
  localparam logic [3:0] TXP_DATA   = 4'h1;
  localparam logic [3:0] TXP_CTRL   = 4'h2;
  localparam logic [3:0] TXP_DIV_LO = 4'h3;
  localparam logic [3:0] TXP_DIV_HI = 4'h4;
  localparam logic [3:0] TXP_LEVEL  = 4'h5;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_PAR_EN   = 1;
  localparam int CTRL_PAR_ODD  = 2;
  localparam int CTRL_TWO_STOP = 3;
  localparam int CTRL_FLUSH    = 4;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // The LEVEL register is only 8 bits wide, so a 256-deep FIFO that is full reads 255.
  function automatic logic [7:0] sat_level(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/krake_tx_fifo_port_if.sv
// Krake register bus between a master and the TX port.
// The strobe is held until ack. ack is a single-cycle pulse with read data valid in that cycle.
interface krake_tx_fifo_port_if;
  logic       stb;
  logic       we;
  logic [3:0] adr;
  logic [7:0] wr_dat;
  logic [7:0] rd_dat;
  logic       ack;

  modport master (output stb, output we, output adr, output wr_dat, input rd_dat, input ack);
  modport slave  (input stb, input we, input adr, input wr_dat, output rd_dat, output ack);
endinterface

// File: rtl/krake_sync_fifo.sv
// Single-clock FIFO with a flush input. Occupancy changes on the clock edge after push or pop.
// A push while full is dropped unless a pop happens in the same cycle. A pop while empty is ignored.
module krake_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      // The pointers wrap on their own because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/krake_tx_fifo_port.sv
// Bus-attached UART transmitter with a TX FIFO, runtime divisor, optional parity and 1/2 stop bits.
// Latency: the start bit is on dout 2 cycles after a DATA write to an idle port. Writes to a full FIFO are dropped and set overflow.
module krake_tx_fifo_port
  import krake_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter logic [7:0]  CTRL_RESET = 8'h01
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  krake_tx_fifo_port_if.slave  bus,
  output logic                 dout,
  output logic                 irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_q;
  logic [7:0]    rd_dat_q;
  logic [7:0]    rd_mux;
  logic [3:0]    ctrl_q;
  logic [15:0]   div_q;
  logic          ovf_q;
  logic          taken;
  logic          wr_taken;
  logic          rd_taken;
  logic          data_push;
  logic          flush;
  logic          pop;
  logic          busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    fifo_rdata;

  tx_state_e     state_q, state_nxt;
  logic [15:0]   baud_q, baud_nxt;
  logic [2:0]    bit_q, bit_nxt;
  logic [7:0]    shreg_q, shreg_nxt;
  logic [15:0]   div_f_q, div_f_nxt;
  logic          par_en_q, par_en_nxt;
  logic          par_bit_q, par_bit_nxt;
  logic          two_stop_q, two_stop_nxt;
  logic          dout_q, dout_nxt;
  logic          launch;
  logic          bit_end;

  assign taken     = bus.stb & ~ack_q;
  assign wr_taken  = taken & bus.we;
  assign rd_taken  = taken & ~bus.we;
  assign data_push = wr_taken & (bus.adr == TXP_DATA);
  assign flush     = wr_taken & (bus.adr == TXP_CTRL) & bus.wr_dat[CTRL_FLUSH];
  assign busy      = (state_q != S_IDLE);
  assign irq_o     = fifo_empty & ~busy;
  assign dout      = dout_q;
  assign bus.ack    = ack_q;
  assign bus.rd_dat = rd_dat_q;

  krake_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (data_push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (bus.wr_dat),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (bus.adr)
      TXP_STATUS: rd_mux = {4'b0, ovf_q, busy, fifo_full, fifo_empty};
      TXP_CTRL:   rd_mux = {4'b0, ctrl_q};
      TXP_DIV_LO: rd_mux = div_q[7:0];
      TXP_DIV_HI: rd_mux = div_q[15:8];
      TXP_LEVEL:  rd_mux = sat_level(9'(fifo_cnt));
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q    <= 1'b0;
      rd_dat_q <= 8'h00;
      ctrl_q   <= CTRL_RESET[3:0];
      div_q    <= DIV_RESET;
      ovf_q    <= 1'b0;
    end else begin
      ack_q    <= bus.stb & ~ack_q;
      rd_dat_q <= rd_taken ? rd_mux : 8'h00;
      if (wr_taken) begin
        case (bus.adr)
          TXP_STATUS: if (bus.wr_dat[STAT_OVF]) ovf_q <= 1'b0;
          TXP_CTRL:   ctrl_q <= bus.wr_dat[3:0];
          TXP_DIV_LO: div_q[7:0] <= bus.wr_dat;
          TXP_DIV_HI: div_q[15:8] <= bus.wr_dat;
          default:    ;
        endcase
      end
      if (data_push & fifo_full & ~pop) ovf_q <= 1'b1;
    end
  end

  assign bit_end = (baud_q == div_f_q);

  always_comb begin
    state_nxt    = state_q;
    baud_nxt     = baud_q + 16'd1;
    bit_nxt      = bit_q;
    shreg_nxt    = shreg_q;
    div_f_nxt    = div_f_q;
    par_en_nxt   = par_en_q;
    par_bit_nxt  = par_bit_q;
    two_stop_nxt = two_stop_q;
    dout_nxt     = dout_q;
    launch       = 1'b0;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_nxt = '0;
        dout_nxt = 1'b1;
        launch   = ctrl_q[CTRL_TX_EN] & ~fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          dout_nxt  = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_q == 3'd7) begin
            state_nxt = par_en_q ? S_PARITY : S_STOP;
            dout_nxt  = par_en_q ? par_bit_q : 1'b1;
            bit_nxt   = 3'd0;
          end else begin
            bit_nxt   = bit_q + 3'd1;
            shreg_nxt = {1'b0, shreg_q[7:1]};
            dout_nxt  = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          baud_nxt  = '0;
          bit_nxt   = 3'd0;
          dout_nxt  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (two_stop_q && bit_q == 3'd0) begin
            bit_nxt = 3'd1;
          end else begin
            state_nxt = S_IDLE;
            dout_nxt  = 1'b1;
            launch    = ctrl_q[CTRL_TX_EN] & ~fifo_empty;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dout_nxt  = 1'b1;
      end
    endcase

    // Frame settings are captured at the pop so that mid-frame CTRL/DIV writes only affect later frames.
    if (launch) begin
      pop          = 1'b1;
      state_nxt    = S_START;
      baud_nxt     = '0;
      bit_nxt      = 3'd0;
      shreg_nxt    = fifo_rdata;
      div_f_nxt    = div_q;
      par_en_nxt   = ctrl_q[CTRL_PAR_EN];
      par_bit_nxt  = (^fifo_rdata) ^ ctrl_q[CTRL_PAR_ODD];
      two_stop_nxt = ctrl_q[CTRL_TWO_STOP];
      dout_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      div_f_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      dout_q     <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      baud_q     <= baud_nxt;
      bit_q      <= bit_nxt;
      shreg_q    <= shreg_nxt;
      div_f_q    <= div_f_nxt;
      par_en_q   <= par_en_nxt;
      par_bit_q  <= par_bit_nxt;
      two_stop_q <= two_stop_nxt;
      dout_q     <= dout_nxt;
    end
  end

endmodule
